// File: rtl/chacha20_pkg.sv
// chacha20_pkg: shared types and constants for the ChaCha20 block sequencer.
//   - SIGMA0..SIGMA3 : "expand 32-byte k" constants (state words 0..3)
//   - DOUBLE_ROUNDS_DEF : default double-round count (ChaCha20 = 10)
//   - state_t        : 16 x 32-bit state, word i at bits [32i+31:32i]
//   - quad_t         : four words fed to one quarter round, a at index 0
//   - seq_state_t    : sequencer FSM encoding
//   - build_state()  : assembles the initial state from key/counter/nonce
package chacha20_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int DOUBLE_ROUNDS_DEF = 10;

  typedef logic [15:0][31:0] state_t;
  typedef logic [3:0][31:0]  quad_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_OUT   = 2'd2
  } seq_state_t;

  // Packed concatenation places word 0 in the least significant slot, so
  // the key lands in words 4..11, counter in 12 and nonce in 13..15.
  function automatic state_t build_state(input logic [255:0] key,
                                         input logic [31:0]  counter,
                                         input logic [95:0]  nonce);
    return {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

endpackage

// File: rtl/chacha20_double_round.sv
// chacha20_double_round: purely combinational ChaCha double round.
//   state_in  : working state before the round
//   state_out : state after a column round followed by a diagonal round
module chacha20_double_round
  import chacha20_pkg::*;
(
  input  state_t state_in,
  output state_t state_out
);

  function automatic quad_t qr(input quad_t q);
    logic [31:0] a, b, c, d;
    a = q[0];
    b = q[1];
    c = q[2];
    d = q[3];
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  quad_t c0, c1, c2, c3;
  quad_t d0, d1, d2, d3;

  // Column round: quad k works on words k, 4+k, 8+k, 12+k.
  assign c0 = qr({state_in[12], state_in[8],  state_in[4], state_in[0]});
  assign c1 = qr({state_in[13], state_in[9],  state_in[5], state_in[1]});
  assign c2 = qr({state_in[14], state_in[10], state_in[6], state_in[2]});
  assign c3 = qr({state_in[15], state_in[11], state_in[7], state_in[3]});

  // Diagonal round: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  // Column word w lives in c{w%4}[w/4].
  assign d0 = qr({c3[3], c2[2], c1[1], c0[0]});
  assign d1 = qr({c0[3], c3[2], c2[1], c1[0]});
  assign d2 = qr({c1[3], c0[2], c3[1], c2[0]});
  assign d3 = qr({c2[3], c1[2], c0[1], c3[0]});

  assign state_out = {d0[3], d3[3], d2[3], d1[3],
                      d1[2], d0[2], d3[2], d2[2],
                      d2[1], d1[1], d0[1], d3[1],
                      d3[0], d2[0], d1[0], d0[0]};

endmodule

// File: rtl/chacha20_block_sequencer.sv
// chacha20_block_sequencer: serial ChaCha20 keystream controller.
// Accepts a command (key, nonce, start counter, block count), runs one
// double round per cycle and emits one 512-bit keystream block per handshake.
//
// Ports:
//   clock, clear_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake (cmd_key, cmd_nonce,
//                               cmd_counter, cmd_blocks)
//   abort                     : synchronous return to IDLE, highest priority
//   ks_valid/ks_ready         : keystream handshake (ks_data, ks_counter, ks_last)
//   busy                      : FSM not in IDLE
//   wrap_err                  : sticky, command truncated by counter wrap
//   dbg_state                 : current FSM state (seq_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and payload stable until then.
//
// Build option CHACHA20_SEQ_ZEROIZE_EN: key, nonce, working/initial state and
// ks_data are cleared on every edge that enters IDLE. Without it they retain
// their last values.
module chacha20_block_sequencer
  import chacha20_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = DOUBLE_ROUNDS_DEF
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [255:0] cmd_key,
  input  logic [95:0]  cmd_nonce,
  input  logic [31:0]  cmd_counter,
  input  logic [15:0]  cmd_blocks,
  input  logic         abort,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] ks_data,
  output logic [31:0]  ks_counter,
  output logic         ks_last,
  output logic         busy,
  output logic         wrap_err,
  output logic [1:0]   dbg_state
);

`ifdef CHACHA20_SEQ_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam int CW = $clog2(DOUBLE_ROUNDS + 1);
  localparam logic [CW-1:0] LAST_ROUND = CW'(DOUBLE_ROUNDS - 1);

  seq_state_t     state_q;
  logic [CW-1:0]  round_cnt;
  logic [255:0]   key_q;
  logic [95:0]    nonce_q;
  logic [31:0]    counter_q;
  logic [15:0]    blocks_left;
  state_t         working_q;
  state_t         init_q;
  state_t         dr_out;
  state_t         ff_sum;
  logic [511:0]   ks_data_q;
  logic [31:0]    ks_counter_q;
  logic           ks_last_q;
  logic           wrap_err_q;
  logic           enter_idle;

  chacha20_double_round u_dr (
    .state_in  (working_q),
    .state_out (dr_out)
  );

  // Feed-forward: the last double round's output plus the initial state.
  for (genvar i = 0; i < 16; i++) begin : g_ff
    assign ff_sum[i] = dr_out[i] + init_q[i];
  end

  always_comb begin
    enter_idle = abort
              || (state_q == ST_IDLE && cmd_valid && cmd_blocks == 16'd0)
              || (state_q == ST_OUT && ks_ready && ks_last_q);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= ST_IDLE;
      round_cnt    <= '0;
      key_q        <= '0;
      nonce_q      <= '0;
      counter_q    <= '0;
      blocks_left  <= '0;
      working_q    <= '0;
      init_q       <= '0;
      ks_data_q    <= '0;
      ks_counter_q <= '0;
      ks_last_q    <= 1'b0;
      wrap_err_q   <= 1'b0;
    end else begin
      if (abort) begin
        state_q   <= ST_IDLE;
        round_cnt <= '0;
        ks_last_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              wrap_err_q <= 1'b0;
              if (cmd_blocks != 16'd0) begin
                key_q       <= cmd_key;
                nonce_q     <= cmd_nonce;
                counter_q   <= cmd_counter;
                blocks_left <= cmd_blocks;
                working_q   <= build_state(cmd_key, cmd_counter, cmd_nonce);
                init_q      <= build_state(cmd_key, cmd_counter, cmd_nonce);
                round_cnt   <= '0;
                state_q     <= ST_ROUND;
              end
            end
          end
          ST_ROUND: begin
            working_q <= dr_out;
            round_cnt <= round_cnt + CW'(1);
            if (round_cnt == LAST_ROUND) begin
              ks_data_q    <= ff_sum;
              ks_counter_q <= counter_q;
              // A block is last either by count or because the counter
              // cannot advance without wrapping.
              ks_last_q    <= (blocks_left == 16'd1) || (counter_q == 32'hFFFF_FFFF);
              round_cnt    <= '0;
              state_q      <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (ks_ready) begin
              ks_last_q <= 1'b0;
              if (ks_last_q) begin
                state_q <= ST_IDLE;
                if (blocks_left > 16'd1) wrap_err_q <= 1'b1;
              end else begin
                counter_q   <= counter_q + 32'd1;
                blocks_left <= blocks_left - 16'd1;
                working_q   <= build_state(key_q, counter_q + 32'd1, nonce_q);
                init_q      <= build_state(key_q, counter_q + 32'd1, nonce_q);
                round_cnt   <= '0;
                state_q     <= ST_ROUND;
              end
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            round_cnt <= '0;
          end
        endcase
      end
      // Later assignments win, so this overrides any load made above.
      if (ZEROIZE && enter_idle) begin
        key_q     <= '0;
        nonce_q   <= '0;
        working_q <= '0;
        init_q    <= '0;
        ks_data_q <= '0;
      end
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign ks_valid   = (state_q == ST_OUT);
  assign ks_data    = ks_data_q;
  assign ks_counter = ks_counter_q;
  assign ks_last    = ks_last_q;
  assign wrap_err   = wrap_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_chacha20_block_sequencer.sv
// tb_chacha20_block_sequencer: table-driven and randomized checks of the
// ChaCha20 block sequencer against a word-array ChaCha20 reference model.
module tb_chacha20_block_sequencer;

  localparam int DR = 10;
  localparam int W  = 545;  // {last, counter[31:0], data[511:0]}

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [255:0] cmd_key = '0;
  logic [95:0]  cmd_nonce = '0;
  logic [31:0]  cmd_counter = '0;
  logic [15:0]  cmd_blocks = '0;
  logic         abort = 1'b0;
  logic         ks_valid;
  logic         ks_ready = 1'b0;
  logic [511:0] ks_data;
  logic [31:0]  ks_counter;
  logic         ks_last;
  logic         busy;
  logic         wrap_err;
  logic [1:0]   dbg_state;

  chacha20_block_sequencer #(.DOUBLE_ROUNDS(DR)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_key     (cmd_key),
    .cmd_nonce   (cmd_nonce),
    .cmd_counter (cmd_counter),
    .cmd_blocks  (cmd_blocks),
    .abort       (abort),
    .ks_valid    (ks_valid),
    .ks_ready    (ks_ready),
    .ks_data     (ks_data),
    .ks_counter  (ks_counter),
    .ks_last     (ks_last),
    .busy        (busy),
    .wrap_err    (wrap_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [511:0] last_ks;
  logic [31:0]  last_ctr;
  logic         last_last;

  int qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] key,
                                             input logic [95:0] nonce,
                                             input logic [31:0] ctr);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    int a, b, c, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4 + j] = key[32 * j +: 32];
    s[12] = ctr;
    for (int j = 0; j < 3; j++) s[13 + j] = nonce[32 * j +: 32];
    x = s;
    for (int rnd = 0; rnd < DR; rnd++) begin
      for (int q = 0; q < 8; q++) begin
        a = qi[q][0]; b = qi[q][1]; c = qi[q][2]; d = qi[q][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Issues one command from IDLE, consumes every block, checks each against
  // the model, and checks wrap_err / return to IDLE at the end.
  task automatic run_cmd(input logic [255:0] key, input logic [95:0] nonce,
                         input logic [31:0] ctr, input logic [15:0] blocks,
                         input int stall, output int got);
    longint avail;
    int n;
    bit exp_wrap;
    int lat;
    logic [W-1:0] e;
    avail = 64'h1_0000_0000 - longint'(ctr);
    n = (longint'(blocks) > avail) ? int'(avail) : int'(blocks);
    exp_wrap = (longint'(blocks) > avail);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), ctr + 32'(i), ref_block(key, nonce, ctr + 32'(i))});
    got = 0;
    ks_ready = (stall == 0);
    cmd_key = key; cmd_nonce = nonce; cmd_counter = ctr; cmd_blocks = blocks;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    if (blocks == 16'd0) begin
      chk("wrap_err cleared by empty cmd", wrap_err, 0);
      repeat (DR + 2) begin
        @(posedge clock); #1;
        chk("empty cmd ks_valid", ks_valid, 0);
        chk("empty cmd busy", busy, 0);
        chk("empty cmd cmd_ready", cmd_ready, 1);
      end
    end
    while (exp_q.size() > 0) begin
      lat = 0;
      while (!ks_valid && lat < 100) begin
        // Junk commands while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_counter = $urandom;
        cmd_blocks = 16'd1;
        @(posedge clock); #1;
        lat++;
      end
      cmd_valid = 1'b0;
      if (!ks_valid) begin
        checks++; errors++;
        $display("FAIL ks_valid timeout: got 0 after %0d cycles expected 1", lat);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      // Accept cycle, then DR round cycles; valid in the following cycle.
      chk("ks_valid latency", lat, DR);
      chk("cmd_ready while busy", cmd_ready, 0);
      chk("busy while busy", busy, 1);
      chk("ks_data", ks_data, e[511:0]);
      chk("ks_counter", ks_counter, e[543:512]);
      chk("ks_last", ks_last, e[544]);
      for (int s = 0; s < stall; s++) begin
        @(posedge clock); #1;
        chk("stall ks_valid", ks_valid, 1);
        chk("stall ks_data", ks_data, e[511:0]);
        chk("stall ks_last", ks_last, e[544]);
      end
      last_ks = ks_data; last_ctr = ks_counter; last_last = ks_last;
      ks_ready = 1'b1;
      @(posedge clock); #1;
      ks_ready = (stall == 0);
      got++;
    end
    if (blocks != 16'd0) begin
      chk("wrap_err after cmd", wrap_err, exp_wrap);
      chk("idle after cmd", dbg_state, 0);
      chk("cmd_ready after cmd", cmd_ready, 1);
    end
    ks_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [15:0]  blocks;
    int           stall;
    int           exp_blocks;
    bit           exp_wrap;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [255:0] rk;
    logic [95:0]  rn;
    int got;
    bit seen;

    for (int j = 0; j < 32; j++) rfc_key[8 * j +: 8] = 8'(j);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    for (int j = 0; j < 8; j++) rk[32 * j +: 32] = $urandom;
    for (int j = 0; j < 3; j++) rn[32 * j +: 32] = $urandom;

    vecs[0] = '{rfc_key, rfc_nonce, 32'd1,          16'd1, 0, 1, 1'b0};
    vecs[1] = '{rfc_key, rfc_nonce, 32'd1,          16'd3, 5, 3, 1'b0};
    vecs[2] = '{rfc_key, rfc_nonce, 32'hFFFF_FFFE,  16'd4, 2, 2, 1'b1};
    vecs[3] = '{rfc_key, rfc_nonce, 32'd7,          16'd0, 0, 0, 1'b0};
    vecs[4] = '{rk,      rn,        32'hFFFF_FFFF,  16'd1, 1, 1, 1'b0};
    vecs[5] = '{rk,      rn,        $urandom,       16'd2, 0, 2, 1'b0};
    if (vecs[5].ctr > 32'hFFFF_FFF0) vecs[5].ctr = 32'h1234_5678;

    // Reset values while clear_n is held low.
    #1;
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset ks_valid", ks_valid, 0);
    chk("reset ks_last", ks_last, 0);
    chk("reset busy", busy, 0);
    chk("reset wrap_err", wrap_err, 0);
    chk("reset ks_data", ks_data, 0);
    chk("reset ks_counter", ks_counter, 0);
    chk("reset state", dbg_state, 0);
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven commands.
    for (int v = 0; v < 6; v++) begin
      run_cmd(vecs[v].key, vecs[v].nonce, vecs[v].ctr, vecs[v].blocks, vecs[v].stall, got);
      chk($sformatf("vec%0d block count", v), got, vecs[v].exp_blocks);
      chk($sformatf("vec%0d wrap_err", v), wrap_err, vecs[v].exp_wrap);
      if (v == 0) begin
        chk("rfc word0", last_ks[31:0], 32'he4e7f110);
        chk("rfc word1", last_ks[63:32], 32'h15593bd1);
        chk("rfc word15", last_ks[511:480], 32'h4e3c50a2);
        chk("rfc ks_counter", last_ctr, 32'd1);
        chk("rfc ks_last", last_last, 1);
      end
      if (v == 1) chk("3-block last counter", last_ctr, 32'd3);
      if (v == 2) chk("wrap last counter", last_ctr, 32'hFFFF_FFFF);
    end

    // Abort during ROUND at round_cnt = 4.
    ks_ready = 1'b1;
    cmd_key = rfc_key; cmd_nonce = rfc_nonce; cmd_counter = 32'd1; cmd_blocks = 16'd1;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("busy before abort", busy, 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort state idle", dbg_state, 0);
    chk("abort busy", busy, 0);
    chk("abort cmd_ready", cmd_ready, 1);
    chk("abort ks_valid", ks_valid, 0);
`ifdef CHACHA20_SEQ_ZEROIZE_EN
    chk("zeroize working", dut.working_q, 0);
    chk("zeroize initial", dut.init_q, 0);
    chk("zeroize key", dut.key_q, 0);
    chk("zeroize ks_data", ks_data, 0);
`endif
    seen = 1'b0;
    repeat (DR + 4) begin
      @(posedge clock); #1;
      if (ks_valid) seen = 1'b1;
    end
    chk("no ks_valid after abort", seen, 0);
    run_cmd(rfc_key, rfc_nonce, 32'd1, 16'd1, 0, got);
    chk("rfc after abort word0", last_ks[31:0], 32'he4e7f110);

    // Abort in OUT with ks_ready high: no transfer, back to IDLE.
    ks_ready = 1'b0;
    cmd_counter = 32'd5; cmd_blocks = 16'd2;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (DR) @(posedge clock);
    #1;
    chk("ks_valid before out abort", ks_valid, 1);
    ks_ready = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    ks_ready = 1'b0;
    chk("out abort ks_valid", ks_valid, 0);
    chk("out abort state", dbg_state, 0);
    chk("out abort wrap_err", wrap_err, 0);

    // Randomized commands.
    for (int r = 0; r < 5; r++) begin
      logic [31:0] c;
      for (int j = 0; j < 8; j++) rk[32 * j +: 32] = $urandom;
      for (int j = 0; j < 3; j++) rn[32 * j +: 32] = $urandom;
      c = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      run_cmd(rk, rn, c, 16'($urandom_range(0, 3)), $urandom_range(0, 3), got);
    end

    // clear_n asserted while a block is waiting in OUT.
    ks_ready = 1'b0;
    cmd_key = rfc_key; cmd_nonce = rfc_nonce; cmd_counter = 32'd1; cmd_blocks = 16'd2;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (DR) @(posedge clock);
    #1;
    chk("ks_valid before clear", ks_valid, 1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("clear ks_valid", ks_valid, 0);
    chk("clear ks_data", ks_data, 0);
    chk("clear ks_counter", ks_counter, 0);
    chk("clear cmd_ready", cmd_ready, 1);
    chk("clear busy", busy, 0);
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock); #1;
    chk("state idle after clear", dbg_state, 0);
    chk("ks_valid idle after clear", ks_valid, 0);

    // Final report.
    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
